vc_round_robin_dispatcher: RTL and testbench

// Inverse of round-robin arbitration: one val/rdy input stream is spread

---
 rtl/vc_round_robin_dispatcher.sv | 133 +++++++++++++
 tb/tb_vc_round_robin_dispatcher.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/vc_round_robin_dispatcher.sv
// vc_round_robin_dispatcher
//   Spreads one val/rdy input stream across NUM_OUTS val/rdy consumers in
//   rotating order. Each output owns a one-entry buffer. An accepted message
//   lands in the highest-priority empty buffer. That output then becomes the
//   lowest priority.
//
// Ports
//   clk      in   clock, posedge
//   reset    in   asynchronous, active-low
//   in_val   in   input message valid
//   in_rdy   out  at least one buffer is empty (state only, never out_rdy)
//   in_msg   in   [MSG_NBITS-1:0] input message
//   out_val  out  [NUM_OUTS-1:0] buffer i holds a message (registered)
//   out_rdy  in   [NUM_OUTS-1:0] consumer i accepts its message
//   out_msg  out  [NUM_OUTS*MSG_NBITS-1:0] buffer i at slice i (registered)

// One-entry output buffer for a single consumer port.
module vc_round_robin_dispatcher_lane #(
  parameter int MSG_NBITS = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_enq,
  input  logic [MSG_NBITS-1:0] i_msg,
  input  logic                 i_deq_rdy,
  output logic                 o_full,
  output logic [MSG_NBITS-1:0] o_msg
);
  logic                 r_full;
  logic [MSG_NBITS-1:0] r_buf;
  logic                 r_hold;
  logic [MSG_NBITS-1:0] r_msg_q;

  // Enqueue only ever targets an empty buffer, so enq and deq never collide.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_full <= 1'b0;
      r_buf  <= '0;
    end else begin
      if (i_enq) begin
        r_full <= 1'b1;
        r_buf  <= i_msg;
      end else if (r_full && i_deq_rdy) begin
        r_full <= 1'b0;
      end
    end
  end

  assign o_full = r_full;
  assign o_msg  = r_buf;

  // Shadow of last cycle's held message. An asynchronous reset clears the
  // hold flag, so a dropped message is never flagged as unstable.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_hold  <= 1'b0;
      r_msg_q <= '0;
    end else begin
      r_hold  <= r_full & ~i_deq_rdy;
      r_msg_q <= r_buf;
    end
  end

  always_ff @(posedge clk) begin
    if (reset && r_hold) assert (r_buf == r_msg_q);
  end
endmodule

module vc_round_robin_dispatcher #(
  parameter int                  NUM_OUTS           = 2,
  parameter int                  MSG_NBITS          = 8,
  parameter logic [NUM_OUTS-1:0] RESET_PRIORITY_VAL = 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          in_val,
  output logic                          in_rdy,
  input  logic [MSG_NBITS-1:0]          in_msg,
  output logic [NUM_OUTS-1:0]           out_val,
  input  logic [NUM_OUTS-1:0]           out_rdy,
  output logic [NUM_OUTS*MSG_NBITS-1:0] out_msg
);
  logic [NUM_OUTS-1:0]                r_prio;
  logic [NUM_OUTS-1:0]                w_full;
  logic [NUM_OUTS-1:0]                w_avail;
  logic [NUM_OUTS-1:0]                w_target;
  logic [NUM_OUTS-1:0][MSG_NBITS-1:0] w_lane_msg;
  logic [2*NUM_OUTS-1:0]              w_dbl;
  logic [2*NUM_OUTS-1:0]              w_dbl_prio;
  logic [2*NUM_OUTS-1:0]              w_gnt;
  logic                               w_enq;

  assign w_avail = ~w_full;
  assign in_rdy  = |w_avail;
  assign w_enq   = in_val & in_rdy;

  // Variable-priority pick with wrap: on the doubled request vector,
  // subtracting the priority bit clears everything from the priority bit up
  // to the first request at or above it. AND-ing with the complement leaves
  // only that first request. The two halves fold the wrap-around back.
  assign w_dbl      = {w_avail, w_avail};
  assign w_dbl_prio = {{NUM_OUTS{1'b0}}, r_prio};
  assign w_gnt      = w_dbl & ~(w_dbl - w_dbl_prio);
  assign w_target   = w_gnt[NUM_OUTS-1:0] | w_gnt[2*NUM_OUTS-1:NUM_OUTS];

  // Rotation only advances on an accepted input.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)     r_prio <= RESET_PRIORITY_VAL;
    else if (w_enq) r_prio <= {w_target[NUM_OUTS-2:0], w_target[NUM_OUTS-1]};
  end

  for (genvar i = 0; i < NUM_OUTS; i++) begin : g_lane
    vc_round_robin_dispatcher_lane #(.MSG_NBITS(MSG_NBITS)) u_lane (
      .clk       (clk),
      .reset     (reset),
      .i_enq     (w_enq & w_target[i]),
      .i_msg     (in_msg),
      .i_deq_rdy (out_rdy[i]),
      .o_full    (w_full[i]),
      .o_msg     (w_lane_msg[i])
    );
  end

  assign out_val = w_full;
  assign out_msg = w_lane_msg;

  always_ff @(posedge clk) begin
    if (reset) begin
      assert ($onehot(r_prio));
      if (in_rdy) assert ($onehot(w_target));
    end
  end
endmodule

// File: tb/tb_vc_round_robin_dispatcher.sv
module tb_vc_round_robin_dispatcher;
  localparam int N = 4;
  localparam int W = 8;

  logic           clk = 1'b0;
  logic           reset;
  logic           in_val;
  logic           in_rdy;
  logic [W-1:0]   in_msg;
  logic [N-1:0]   out_val;
  logic [N-1:0]   out_rdy;
  logic [N*W-1:0] out_msg;
  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  vc_round_robin_dispatcher #(
    .NUM_OUTS(N), .MSG_NBITS(W), .RESET_PRIORITY_VAL(4'b0001)
  ) dut (
    .clk(clk), .reset(reset),
    .in_val(in_val), .in_rdy(in_rdy), .in_msg(in_msg),
    .out_val(out_val), .out_rdy(out_rdy), .out_msg(out_msg)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Called 1 time unit after a posedge: pulse lasts entirely between edges.
  task automatic do_reset;
    reset = 1'b0;
    #2;
    reset = 1'b1;
  endtask

  function automatic logic [W-1:0] pm(input int p);
    return out_msg[p*W +: W];
  endfunction

  logic [15:0] pat;
  int          exp_p;

  initial begin
    // 1. reset behaviour and first message
    reset = 1'b0; in_val = 1'b1; in_msg = 8'hA1; out_rdy = '0;
    #3;
    chk("rst_out_val", out_val, 4'b0000);
    chk("rst_in_rdy",  in_rdy,  1'b1);
    chk("rst_out_msg", out_msg, 32'h0);
    tick;
    chk("rst_hold_out_val", out_val, 4'b0000);
    reset = 1'b1;
    tick;
    chk("first_out_val", out_val, 4'b0001);
    chk("first_msg_p0",  pm(0),   8'hA1);
    in_val = 1'b0; out_rdy = 4'b0001;
    tick;
    chk("first_drain", out_val, 4'b0000);

    // 2. rotation at full rate
    do_reset;
    out_rdy = 4'b1111;
    for (int k = 0; k < 6; k++) begin
      in_val = 1'b1; in_msg = 8'h10 + 8'(k);
      tick;
      chk($sformatf("rot_val_%0d", k), out_val, 4'b0001 << (k % 4));
      chk($sformatf("rot_msg_%0d", k), pm(k % 4), 8'h10 + 8'(k));
      chk($sformatf("rot_rdy_%0d", k), in_rdy, 1'b1);
    end
    in_val = 1'b0;
    tick;
    chk("rot_idle", out_val, 4'b0000);

    // 3. skip a stuck port
    do_reset;
    out_rdy = 4'b1101;
    in_val = 1'b1; in_msg = 8'h20; tick;
    chk("skip_0", out_val, 4'b0001);
    in_msg = 8'h21; tick;
    chk("skip_1", out_val, 4'b0010);
    in_msg = 8'h22; tick;
    chk("skip_2", out_val, 4'b0110);
    in_msg = 8'h23; tick;
    chk("skip_3", out_val, 4'b1010);
    in_msg = 8'h24; tick;
    chk("skip_4", out_val, 4'b0011);
    chk("skip_4_msg", pm(0), 8'h24);
    in_msg = 8'h25; tick;
    chk("skip_5", out_val, 4'b0110);
    chk("skip_5_msg", pm(2), 8'h25);
    chk("skip_p1_held", pm(1), 8'h21);
    in_msg = 8'h26; tick;
    chk("skip_6", out_val, 4'b1010);
    chk("skip_6_msg", pm(3), 8'h26);
    in_val = 1'b0;

    // 4. backpressure
    do_reset;
    out_rdy = 4'b0000;
    for (int k = 0; k < 4; k++) begin
      in_val = 1'b1; in_msg = 8'h30 + 8'(k);
      tick;
    end
    chk("bp_full_val", out_val, 4'b1111);
    chk("bp_full_rdy", in_rdy,  1'b0);
    chk("bp_msgs",     out_msg, 32'h33323130);
    in_msg = 8'h34;
    tick;
    chk("bp_stall_val", out_val, 4'b1111);
    chk("bp_stall_msg", out_msg, 32'h33323130);
    out_rdy = 4'b0100;
    tick;
    chk("bp_drain_val", out_val, 4'b1011);
    chk("bp_drain_rdy", in_rdy,  1'b1);
    out_rdy = 4'b0000;
    tick;
    chk("bp_land_val", out_val, 4'b1111);
    chk("bp_land_msg", pm(2),   8'h34);
    in_val = 1'b0;

    // 5. idle gaps: priority advances only on accepted input
    do_reset;
    out_rdy = 4'b1111;
    pat = 16'b1011_0010_1110_0101;
    exp_p = 0;
    for (int k = 0; k < 16; k++) begin
      in_val = pat[k]; in_msg = 8'h40 + 8'(k);
      tick;
      if (pat[k]) begin
        chk($sformatf("gap_val_%0d", k), out_val, 4'b0001 << exp_p);
        chk($sformatf("gap_msg_%0d", k), pm(exp_p), 8'h40 + 8'(k));
        exp_p = (exp_p + 1) % N;
      end else begin
        chk($sformatf("gap_idle_%0d", k), out_val, 4'b0000);
      end
    end
    in_val = 1'b0;

    // 6. async reset mid-stream
    do_reset;
    out_rdy = 4'b0000;
    for (int k = 0; k < 3; k++) begin
      in_val = 1'b1; in_msg = 8'h50 + 8'(k);
      tick;
    end
    in_val = 1'b0;
    chk("ar_pre_val", out_val, 4'b0111);
    #3;
    reset = 1'b0;
    #1;
    chk("ar_val", out_val, 4'b0000);
    chk("ar_msg", out_msg, 32'h0);
    chk("ar_rdy", in_rdy,  1'b1);
    #1;
    reset = 1'b1;
    in_val = 1'b1; in_msg = 8'h60;
    tick;
    chk("ar_prio_val", out_val, 4'b0001);
    chk("ar_prio_msg", pm(0),   8'h60);
    in_val = 1'b0;
    tick;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
